// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: operation codes
// and the controller state encoding.
package addsub_pkg;

   // Operation select as presented on the op input and held in op_q.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Controller states: waiting for a request, stepping through the bits,
   // and the single cycle in which result/cout are presented with done.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage : addsub_pkg

// File: rtl/addsub_bit_cell.sv
// Single-bit add/subtract cell. Purely combinational; the carry/borrow
// register that chains successive bits lives in the serial controller.
module addsub_bit_cell
   import addsub_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic cin,
   input  logic op,
   output logic s,
   output logic cout
);

   logic x_eff;

   // Subtraction reuses the majority carry term with x inverted, which
   // turns the carry into a borrow (~x&y | ~x&c | y&c).
   always_comb begin
      x_eff = x;
      if (op == OP_SUB) begin
         x_eff = ~x;
      end
   end

   // Sum/difference bit is the same parity for both operations.
   assign s    = x ^ y ^ cin;
   assign cout = (x_eff & y) | (x_eff & cin) | (y & cin);

endmodule : addsub_bit_cell

// File: rtl/serial_addsub.sv
// Bit-serial W-bit adder/subtractor. Operands are captured on an accepted
// start and consumed LSB-first, one bit per clock, through a single bit
// cell. After W bit steps the full result and final carry/borrow are
// registered and flagged with a one-cycle done pulse.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int W = 8
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         cout
);

   // The counter only has to reach W-1; the last bit step moves to DONE
   // instead of incrementing, so $clog2(W) bits never wrap early.
   localparam int            CW   = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  res_sh;
   logic [W-1:0]  res_next;
   logic          op_q;
   logic          carry;
   logic          s_bit;
   logic          carry_n;
   logic          accept;
   logic          last_bit;

   // Only an idle controller takes a request; requests while busy are dropped.
   assign accept   = (state == S_IDLE) && start;
   assign last_bit = (state == S_SHIFT) && (cnt == LAST);

   // The new bit enters at the MSB so after W steps bit 0 has reached the LSB.
   assign res_next = {s_bit, res_sh[W-1:1]};

   addsub_bit_cell u_cell (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .cin  (carry),
      .op   (op_q),
      .s    (s_bit),
      .cout (carry_n)
   );

   // Controller: sequences IDLE -> SHIFT (W bit steps) -> DONE and drives
   // the registered busy/done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= S_SHIFT;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               if (cnt == LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: capture operands on accept, shift one bit per SHIFT cycle,
   // and publish result/cout on the step that finishes the last bit. The
   // published values hold until the next operation completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         op_q   <= OP_ADD;
         carry  <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b;
         op_q   <= op;
         carry  <= 1'b0;
         res_sh <= '0;
      end else if (state == S_SHIFT) begin
         a_sh   <= {1'b0, a_sh[W-1:1]};
         b_sh   <= {1'b0, b_sh[W-1:1]};
         res_sh <= res_next;
         carry  <= carry_n;
         if (last_bit) begin
            result <= res_next;
            cout   <= carry_n;
         end
      end
   end

endmodule : serial_addsub
